// File: rtl/pc_pkg.sv
// Shared types for the pico MIPS program counter.
// pc_op_e names the single operation performed each cycle. pc_decode
// priority-encodes the control inputs into that operation.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_REL,
    PC_ABS,
    PC_CALL,
    PC_RET
  } pc_op_e;

  // Only one operation runs per cycle. Any lower-priority request raised in
  // the same cycle is dropped, not queued.
  function automatic pc_op_e pc_decode(input logic halt,
                                       input logic ret,
                                       input logic call,
                                       input logic abs_jump,
                                       input logic rel_branch);
    if (halt)       return PC_HOLD;
    if (ret)        return PC_RET;
    if (call)       return PC_CALL;
    if (abs_jump)   return PC_ABS;
    if (rel_branch) return PC_REL;
    return PC_INC;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Control/status bundle between the decoder/branch logic (master) and the
// program counter (slave).
//   controls : halt, rel_branch, offset, abs_jump, call, ret, target
//   status   : addr, depth, overflow, underflow
interface pc_stack_if #(
  parameter int AddrSz     = 6,
  parameter int StackDepth = 4
) ();
  localparam int DepthW = $clog2(StackDepth + 1);

  logic              halt;
  logic              rel_branch;
  logic [AddrSz-1:0] offset;
  logic              abs_jump;
  logic              call;
  logic              ret;
  logic [AddrSz-1:0] target;
  logic [AddrSz-1:0] addr;
  logic [DepthW-1:0] depth;
  logic              overflow;
  logic              underflow;

  modport master (
    output halt, rel_branch, offset, abs_jump, call, ret, target,
    input  addr, depth, overflow, underflow
  );

  modport slave (
    input  halt, rel_branch, offset, abs_jump, call, ret, target,
    output addr, depth, overflow, underflow
  );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: a LIFO of StackDepth registers.
// Ports: clk, reset (sync, active-high), push/push_data, pop,
//        top (most recent entry, 0 when empty), full, empty, depth.
// A push while full or a pop while empty is ignored. The caller raises
// any error flags.
module pc_ras #(
  parameter int AddrSz     = 6,
  parameter int StackDepth = 4,
  localparam int DepthW    = $clog2(StackDepth + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [AddrSz-1:0] push_data,
  output logic [AddrSz-1:0] top,
  output logic              full,
  output logic              empty,
  output logic [DepthW-1:0] depth
);

  logic [AddrSz-1:0] mem_q [StackDepth];
  logic [AddrSz-1:0] mem_d [StackDepth];
  logic [DepthW-1:0] depth_q, depth_d;

  assign full  = (depth_q == DepthW'(StackDepth));
  assign empty = (depth_q == '0);
  assign depth = depth_q;

  // Entry i holds the element pushed when depth was i. Matching depth
  // against every index avoids an out-of-range read at depth 0 and also
  // works when StackDepth is not a power of two.
  always_comb begin
    top = '0;
    for (int i = 0; i < StackDepth; i++) begin
      if (DepthW'(i + 1) == depth_q) top = mem_q[i];
    end
  end

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && !full) begin
      for (int i = 0; i < StackDepth; i++) begin
        if (DepthW'(i) == depth_q) mem_d[i] = push_data;
      end
      depth_d = depth_q + DepthW'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DepthW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  // The stored entries need no reset. They are only read when depth says
  // they are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with step, relative branch, absolute jump, and
// call/return through a hardware return-address stack.
// Ports: clk, reset (sync, active-high), bus (pc_stack_if.slave). addr
// feeds instruction fetch directly. depth reports the number of valid
// stack entries. overflow and underflow are sticky until reset.
module pc_stack
  import pc_pkg::*;
#(
  parameter int AddrSz     = 6,
  parameter int StackDepth = 4,
  parameter int Step       = 1
) (
  input  logic clk,
  input  logic reset,
  pc_stack_if.slave bus
);
  localparam int DepthW = $clog2(StackDepth + 1);

  pc_op_e            op;
  logic [AddrSz-1:0] addr_q, addr_d;
  logic [AddrSz-1:0] inc_addr;
  logic [AddrSz-1:0] ras_top;
  logic              ras_full, ras_empty;
  logic [DepthW-1:0] ras_depth;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  assign op       = pc_decode(bus.halt, bus.ret, bus.call, bus.abs_jump, bus.rel_branch);
  assign inc_addr = addr_q + AddrSz'(Step);

  // All sums wrap modulo 2^AddrSz. offset is two's complement, so a plain
  // truncated add gives the correct signed branch.
  always_comb begin
    addr_d      = addr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    case (op)
      PC_HOLD: ;
      PC_INC:  addr_d = inc_addr;
      PC_REL:  addr_d = addr_q + bus.offset;
      PC_ABS:  addr_d = bus.target;
      PC_CALL: begin
        addr_d = bus.target;
        if (ras_full) overflow_d = 1'b1;
      end
      PC_RET: begin
        if (ras_empty) begin
          addr_d      = inc_addr;
          underflow_d = 1'b1;
        end else begin
          addr_d = ras_top;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  pc_ras #(
    .AddrSz     (AddrSz),
    .StackDepth (StackDepth)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (op == PC_CALL),
    .pop       (op == PC_RET),
    .push_data (inc_addr),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .depth     (ras_depth)
  );

  assign bus.addr      = addr_q;
  assign bus.depth     = ras_depth;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Two instances share the same stimulus:
  //   inst 0: Step=1, StackDepth=4
  //   inst 1: Step=4, StackDepth=3 (non-power-of-two depth)
  pc_stack_if #(.AddrSz(6), .StackDepth(4)) bus0 ();
  pc_stack_if #(.AddrSz(6), .StackDepth(3)) bus1 ();

  pc_stack #(.AddrSz(6), .StackDepth(4), .Step(1)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  pc_stack #(.AddrSz(6), .StackDepth(3), .Step(4)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  typedef struct {
    int addr;
    int depth;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: one stack of return addresses per instance.
  int m_addr  [2];
  int m_stk   [2][8];
  int m_cnt   [2];
  bit m_ovf   [2];
  bit m_unf   [2];
  int m_step  [2] = '{1, 4};
  int m_maxd  [2] = '{4, 3};

  task automatic model(input int k, input bit r, input bit h, input bit rb,
                       input int off, input bit aj, input bit c, input bit rt,
                       input int tg);
    exp_t e;
    if (r) begin
      m_addr[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end else if (h) begin
    end else if (rt) begin
      if (m_cnt[k] > 0) begin
        m_cnt[k]--;
        m_addr[k] = m_stk[k][m_cnt[k]];
      end else begin
        m_addr[k] = (m_addr[k] + m_step[k]) % 64;
        m_unf[k] = 1;
      end
    end else if (c) begin
      if (m_cnt[k] < m_maxd[k]) begin
        m_stk[k][m_cnt[k]] = (m_addr[k] + m_step[k]) % 64;
        m_cnt[k]++;
      end else begin
        m_ovf[k] = 1;
      end
      m_addr[k] = tg;
    end else if (aj) begin
      m_addr[k] = tg;
    end else if (rb) begin
      m_addr[k] = (m_addr[k] + off) % 64;
    end else begin
      m_addr[k] = (m_addr[k] + m_step[k]) % 64;
    end
    e.addr = m_addr[k]; e.depth = m_cnt[k]; e.ovf = m_ovf[k]; e.unf = m_unf[k];
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit h, input bit rb, input int off,
                     input bit aj, input bit c, input bit rt, input int tg);
    @(negedge clk);
    reset = r;
    bus0.halt = h; bus0.rel_branch = rb; bus0.offset = 6'(off);
    bus0.abs_jump = aj; bus0.call = c; bus0.ret = rt; bus0.target = 6'(tg);
    bus1.halt = h; bus1.rel_branch = rb; bus1.offset = 6'(off);
    bus1.abs_jump = aj; bus1.call = c; bus1.ret = rt; bus1.target = 6'(tg);
    model(0, r, h, rb, off, aj, c, rt, tg);
    model(1, r, h, rb, off, aj, c, rt, tg);
  endtask

  task automatic idle();        cyc(0, 0, 0, 0, 0, 0, 0, 0);  endtask
  task automatic do_rst();      cyc(1, 0, 0, 0, 0, 0, 0, 0);  endtask
  task automatic jump(int t);   cyc(0, 0, 0, 0, 1, 0, 0, t);  endtask
  task automatic call_to(int t); cyc(0, 0, 0, 0, 0, 1, 0, t); endtask
  task automatic do_ret();      cyc(0, 0, 0, 0, 0, 0, 1, 0);  endtask

  task automatic check(input string name, input logic [31:0] act, input int req);
    checks++;
    if (act !== 32'(req)) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle each DUT presents a new state; compare it with the
  // oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check("addr_s1",  32'(bus0.addr),      e.addr);
        check("depth_s1", 32'(bus0.depth),     e.depth);
        check("ovf_s1",   32'(bus0.overflow),  int'(e.ovf));
        check("unf_s1",   32'(bus0.underflow), int'(e.unf));
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check("addr_s4",  32'(bus1.addr),      e.addr);
        check("depth_s4", 32'(bus1.depth),     e.depth);
        check("ovf_s4",   32'(bus1.overflow),  int'(e.ovf));
        check("unf_s4",   32'(bus1.underflow), int'(e.unf));
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus0.halt = 0; bus0.rel_branch = 0; bus0.offset = 0; bus0.abs_jump = 0;
    bus0.call = 0; bus0.ret = 0; bus0.target = 0;
    bus1.halt = 0; bus1.rel_branch = 0; bus1.offset = 0; bus1.abs_jump = 0;
    bus1.call = 0; bus1.ret = 0; bus1.target = 0;

    // Reset, idle count-up, then reset again mid-count.
    do_rst(); do_rst();
    repeat (5) idle();
    do_rst(); idle();

    // Relative branch backwards, absolute jump, wrap at the top.
    jump(10);
    cyc(0, 0, 1, 6'b111101, 0, 0, 0, 0);
    jump(40);
    jump(63); idle(); idle();
    jump(2); cyc(0, 0, 1, 6'b111110, 0, 0, 0, 0);

    // Simple call and return.
    jump(8); call_to(20); idle(); idle(); do_ret();

    // Nested calls past the stack capacity, then unwind past empty.
    do_rst();
    call_to(10); call_to(20); call_to(30); call_to(40); call_to(50);
    repeat (5) do_ret();

    // Halt freezes everything, even with call asserted. Reset beats halt.
    repeat (5) cyc(0, 1, 0, 0, 0, 1, 0, 7);
    call_to(7);
    cyc(1, 1, 0, 0, 0, 1, 0, 7);

    // ret wins over call and abs_jump in the same cycle.
    jump(32); call_to(50);
    cyc(0, 0, 0, 0, 1, 1, 1, 12);
    idle(); idle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      bit r, h, rb, aj, c, rt;
      r  = ($urandom_range(0, 99) < 2);
      h  = ($urandom_range(0, 99) < 8);
      rt = ($urandom_range(0, 99) < 18);
      c  = ($urandom_range(0, 99) < 22);
      aj = ($urandom_range(0, 99) < 12);
      rb = ($urandom_range(0, 99) < 15);
      cyc(r, h, rb, int'($urandom_range(0, 63)), aj, c, rt,
          int'($urandom_range(0, 63)));
    end
    idle();

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q0.size() + exp_q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
